// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-command and response signals for mem_port_arbiter.
// The arbiter connects through the slave modport; the requesters and memory model use master.
interface mem_port_arbiter_if;
    logic        i_IF_ReqValid;
    logic        o_IF_ReqReady;
    logic [31:0] i_IF_Addr;

    logic        i_D_ReqValid;
    logic        o_D_ReqReady;
    logic [31:0] i_D_Addr;
    logic [31:0] i_D_WData;
    logic [3:0]  i_D_ByteEnable;
    logic        i_D_Write;

    logic        o_IF_RespValid;
    logic        o_D_RespValid;
    logic [31:0] o_RData;

    logic        o_Mem_Valid;
    logic        i_Mem_Ready;
    logic [31:0] o_Mem_Addr;
    logic [31:0] o_Mem_WData;
    logic [3:0]  o_Mem_ByteEnable;
    logic        o_Mem_Write;

    logic        i_Mem_RespValid;
    logic [31:0] i_Mem_RData;

    logic        o_Busy;

    modport slave (
        input  i_IF_ReqValid, i_IF_Addr,
        input  i_D_ReqValid, i_D_Addr, i_D_WData, i_D_ByteEnable, i_D_Write,
        input  i_Mem_Ready, i_Mem_RespValid, i_Mem_RData,
        output o_IF_ReqReady, o_D_ReqReady,
        output o_IF_RespValid, o_D_RespValid, o_RData,
        output o_Mem_Valid, o_Mem_Addr, o_Mem_WData, o_Mem_ByteEnable, o_Mem_Write,
        output o_Busy
    );

    modport master (
        output i_IF_ReqValid, i_IF_Addr,
        output i_D_ReqValid, i_D_Addr, i_D_WData, i_D_ByteEnable, i_D_Write,
        output i_Mem_Ready, i_Mem_RespValid, i_Mem_RData,
        input  o_IF_ReqReady, o_D_ReqReady,
        input  o_IF_RespValid, o_D_RespValid, o_RData,
        input  o_Mem_Valid, o_Mem_Addr, o_Mem_WData, o_Mem_ByteEnable, o_Mem_Write,
        input  o_Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto a single memory port, one transaction in flight.
// Define ARB_STARVATION_GUARD_EN to let a starved fetch win after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gStarveLimitCheck
        $error("mem_port_arbiter: STARVE_LIMIT must lie within 1..15");
    end

    state_t      state_q, state_d;
    logic        ownerData_q, ownerData_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        write_q, write_d;
    logic [31:0] rdata_q, rdata_d;

    logic        grantIf;
    logic        grantD;
    logic        fetchPriority;

`ifdef ARB_STARVATION_GUARD_EN
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    logic [3:0] starveCnt_q, starveCnt_d;

    // Counts data grants that bypassed a waiting fetch; a fetch grant resets the tally.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (grantIf) begin
            starveCnt_d = 4'd0;
        end else if (grantD && bus.i_IF_ReqValid && (starveCnt_q != StarveMax)) begin
            starveCnt_d = starveCnt_q + 4'd1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            starveCnt_q <= 4'd0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

    assign fetchPriority = (starveCnt_q == StarveMax);
`else
    assign fetchPriority = 1'b0;
`endif

    always_comb begin
        grantIf = 1'b0;
        grantD  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.i_IF_ReqValid && (!bus.i_D_ReqValid || fetchPriority)) begin
                grantIf = 1'b1;
            end else if (bus.i_D_ReqValid) begin
                grantD = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ownerData_d = ownerData_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        write_d     = write_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            IDLE: begin
                // Fetches are always full-word reads, so their command fields are fixed here.
                if (grantIf) begin
                    ownerData_d = 1'b0;
                    addr_d      = bus.i_IF_Addr;
                    wdata_d     = 32'd0;
                    be_d        = 4'b1111;
                    write_d     = 1'b0;
                    state_d     = ISSUE;
                end else if (grantD) begin
                    ownerData_d = 1'b1;
                    addr_d      = bus.i_D_Addr;
                    wdata_d     = bus.i_D_WData;
                    be_d        = bus.i_D_ByteEnable;
                    write_d     = bus.i_D_Write;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.i_Mem_Ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.i_Mem_RespValid) begin
                    rdata_d = bus.i_Mem_RData;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= IDLE;
            ownerData_q <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            write_q     <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            ownerData_q <= ownerData_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.o_IF_ReqReady    = grantIf;
    assign bus.o_D_ReqReady     = grantD;
    assign bus.o_Mem_Valid      = (state_q == ISSUE);
    assign bus.o_Mem_Addr       = addr_q;
    assign bus.o_Mem_WData      = wdata_q;
    assign bus.o_Mem_ByteEnable = be_q;
    assign bus.o_Mem_Write      = write_q;
    assign bus.o_IF_RespValid   = (state_q == DONE) && !ownerData_q;
    assign bus.o_D_RespValid    = (state_q == DONE) && ownerData_q;
    assign bus.o_RData          = rdata_q;
    assign bus.o_Busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, scoreboarded bench for mem_port_arbiter: grant order, command fields and responses
// are predicted as stimulus is issued and checked by a monitor as the DUT produces them.
module tb_mem_port_arbiter;

    localparam int StarveLimit = 4;

`ifdef ARB_STARVATION_GUARD_EN
    localparam bit GuardEn = 1'b1;
`else
    localparam bit GuardEn = 1'b0;
`endif

    typedef struct {
        logic        isData;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        write;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cycle = 0;
    int   compared = 0;
    int   mismatched = 0;

    txn_t cmdQ[$];
    txn_t respQ[$];
    logic grantExpQ[$];

    txn_t        monTxn;
    logic        monExpData;
    logic [31:0] memRData = 32'd0;

    always #10 clk = ~clk;
    always @(posedge clk) cycle++;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(StarveLimit)) dut (
        .i_Clock  (clk),
        .i_Reset_n(rst_n),
        .bus      (bus)
    );

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: read data for the accepted address is ready by the following WAIT cycle.
    always @(posedge clk) begin
        if (bus.o_Mem_Valid && bus.i_Mem_Ready) memRData <= memData(bus.o_Mem_Addr);
    end
    always @(memRData) bus.i_Mem_RData = memRData;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkPresent(input string tag, input int count);
        compared++;
        assert (count > 0) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed queue size %0d expected nonzero", tag, count);
        end
    endtask

    task automatic applyStimulus(input logic ifValid, input logic [31:0] ifAddr,
                                 input logic dValid, input logic [31:0] dAddr,
                                 input logic [31:0] dWData, input logic [3:0] dBe, input logic dWrite);
        bus.i_IF_ReqValid  = ifValid;
        bus.i_IF_Addr      = ifAddr;
        bus.i_D_ReqValid   = dValid;
        bus.i_D_Addr       = dAddr;
        bus.i_D_WData      = dWData;
        bus.i_D_ByteEnable = dBe;
        bus.i_D_Write      = dWrite;
    endtask

    task automatic expectTxn(input logic isData, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic write, input logic withResp);
        txn_t t;
        t.isData = isData;
        t.addr   = addr;
        t.wdata  = wdata;
        t.be     = be;
        t.write  = write;
        t.rdata  = memData(addr);
        grantExpQ.push_back(isData);
        cmdQ.push_back(t);
        if (withResp) respQ.push_back(t);
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic waitResp(input logic wantData, output int latency);
        latency = -1;
        for (int i = 1; i <= 30; i++) begin
            nextCycle();
            settle();
            if ((wantData && bus.o_D_RespValid) || (!wantData && bus.o_IF_RespValid)) begin
                latency = i;
                break;
            end
        end
    endtask

    // Monitor: every grant, accepted command and response must match the next scoreboard entry.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            if (bus.o_IF_ReqReady || bus.o_D_ReqReady) begin
                checkPresent("grant_expected", grantExpQ.size());
                if (grantExpQ.size() > 0) begin
                    monExpData = grantExpQ.pop_front();
                    checkOutput("grant_owner", {bus.o_IF_ReqReady, bus.o_D_ReqReady},
                                monExpData ? 2'b01 : 2'b10);
                end
            end
            if (bus.o_Mem_Valid && bus.i_Mem_Ready) begin
                checkPresent("cmd_expected", cmdQ.size());
                if (cmdQ.size() > 0) begin
                    monTxn = cmdQ.pop_front();
                    checkOutput("cmd_fields",
                                {bus.o_Mem_Addr, bus.o_Mem_WData, bus.o_Mem_ByteEnable, bus.o_Mem_Write},
                                {monTxn.addr, monTxn.wdata, monTxn.be, monTxn.write});
                end
            end
            if (bus.o_IF_RespValid || bus.o_D_RespValid) begin
                checkPresent("resp_expected", respQ.size());
                if (respQ.size() > 0) begin
                    monTxn = respQ.pop_front();
                    checkOutput("resp_owner_data", {bus.o_IF_RespValid, bus.o_D_RespValid, bus.o_RData},
                                {!monTxn.isData, monTxn.isData, monTxn.rdata});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed no completion expected finish before 400000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int gD;
        logic isIf;

        rst_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        bus.i_Mem_Ready     = 1'b1;
        bus.i_Mem_RespValid = 1'b1;
        repeat (2) nextCycle();
        settle();
        checkOutput("reset_ctrl",
                    {bus.o_IF_ReqReady, bus.o_D_ReqReady, bus.o_IF_RespValid, bus.o_D_RespValid,
                     bus.o_Mem_Valid, bus.o_Mem_Write, bus.o_Busy}, 7'd0);
        checkOutput("reset_data", {bus.o_RData, bus.o_Mem_Addr, bus.o_Mem_WData, bus.o_Mem_ByteEnable}, 100'd0);
        nextCycle();
        rst_n = 1'b1;

        // Single fetch with an immediately responsive memory.
        expectTxn(1'b0, 32'h0000_0100, 32'd0, 4'hF, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        settle();
        checkOutput("fetch_ready", {bus.o_IF_ReqReady, bus.o_D_ReqReady}, 2'b10);
        @(posedge clk); #1;
        bus.i_IF_ReqValid = 1'b0;
        waitResp(1'b0, lat);
        checkOutput("fetch_latency", lat, 3);
        checkOutput("fetch_rdata", bus.o_RData, 32'h0000_0013);
        nextCycle();
        settle();
        checkOutput("rdata_retained", {bus.o_RData, bus.o_Busy}, {32'h0000_0013, 1'b0});

        // Simultaneous requests: data first, then the held fetch back to back.
        expectTxn(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1'b1);
        expectTxn(1'b0, 32'h0000_0000, 32'd0, 4'hF, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0000, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 1'b1);
        settle();
        checkOutput("simul_ready", {bus.o_IF_ReqReady, bus.o_D_ReqReady}, 2'b01);
        gD = cycle;
        @(posedge clk); #1;
        bus.i_D_ReqValid = 1'b0;
        waitResp(1'b1, lat);
        checkOutput("data_latency", lat, 3);
        nextCycle();
        settle();
        checkOutput("b2b_if_ready", {bus.o_IF_ReqReady, bus.o_D_ReqReady}, 2'b10);
        checkOutput("b2b_gap", cycle - gD, 4);
        @(posedge clk); #1;
        bus.i_IF_ReqValid = 1'b0;
        waitResp(1'b0, lat);
        checkOutput("b2b_if_latency", lat, 3);

        // Memory stalls in ISSUE while a data request waits.
        bus.i_Mem_Ready = 1'b0;
        expectTxn(1'b0, 32'h0000_0044, 32'd0, 4'hF, 1'b0, 1'b1);
        expectTxn(1'b1, 32'h0000_3000, 32'h0000_1111, 4'b1100, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0044, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        settle();
        checkOutput("stall_if_ready", {bus.o_IF_ReqReady, bus.o_D_ReqReady}, 2'b10);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'd0, 1'b1, 32'h0000_3000, 32'h0000_1111, 4'b1100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            settle();
            checkOutput("issue_hold",
                        {bus.o_Mem_Valid, bus.o_Mem_Addr, bus.o_Mem_WData, bus.o_Mem_ByteEnable, bus.o_Mem_Write,
                         bus.o_IF_ReqReady, bus.o_D_ReqReady, bus.o_Busy},
                        {1'b1, 32'h0000_0044, 32'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        nextCycle();
        bus.i_Mem_Ready = 1'b1;
        waitResp(1'b0, lat);
        checkOutput("stall_release_latency", lat, 2);
        nextCycle();
        settle();
        checkOutput("held_data_ready", {bus.o_IF_ReqReady, bus.o_D_ReqReady}, 2'b01);
        @(posedge clk); #1;
        bus.i_D_ReqValid = 1'b0;
        waitResp(1'b1, lat);
        checkOutput("held_data_latency", lat, 3);

        // Reset while waiting for the memory response abandons the transaction.
        bus.i_Mem_RespValid = 1'b0;
        expectTxn(1'b0, 32'h0000_0080, 32'd0, 4'hF, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        @(posedge clk); #1;
        bus.i_IF_ReqValid = 1'b0;
        repeat (2) nextCycle();
        settle();
        checkOutput("wait_busy", {bus.o_Busy, bus.o_Mem_Valid}, 2'b10);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid", {bus.o_Busy, bus.o_Mem_Valid, bus.o_IF_RespValid, bus.o_D_RespValid}, 4'd0);
        nextCycle();
        rst_n = 1'b1;
        bus.i_Mem_RespValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            settle();
            checkOutput("no_resp_after_reset", {bus.o_IF_RespValid, bus.o_D_RespValid, bus.o_Busy}, 3'd0);
        end
        expectTxn(1'b1, 32'h0000_0500, 32'h0000_0000, 4'hF, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b1, 32'h0000_0500, 32'h0000_0000, 4'hF, 1'b0);
        settle();
        checkOutput("post_reset_ready", {bus.o_IF_ReqReady, bus.o_D_ReqReady}, 2'b01);
        @(posedge clk); #1;
        bus.i_D_ReqValid = 1'b0;
        waitResp(1'b1, lat);
        checkOutput("post_reset_latency", lat, 3);

        // Both requesters held continuously: grant order depends on the starvation guard.
        for (int k = 0; k < 10; k++) begin
            isIf = GuardEn && ((k % (StarveLimit + 1)) == StarveLimit);
            if (isIf) expectTxn(1'b0, 32'h0000_0600, 32'd0, 4'hF, 1'b0, 1'b1);
            else      expectTxn(1'b1, 32'h0000_0700, 32'h1234_5678, 4'hF, 1'b0, 1'b1);
        end
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0600, 1'b1, 32'h0000_0700, 32'h1234_5678, 4'hF, 1'b0);
        settle();
        for (int i = 0; i < 80 && grantExpQ.size() > 0; i++) begin
            nextCycle();
            settle();
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        for (int i = 0; i < 20 && respQ.size() > 0; i++) begin
            nextCycle();
        end
        repeat (2) nextCycle();
        settle();
        checkOutput("queues_drained", cmdQ.size() + respQ.size() + grantExpQ.size(), 0);
        checkOutput("final_idle", {bus.o_Busy, bus.o_Mem_Valid}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending (range 1..15).
REQ-002 SHALL have ports: i_Clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have ports: i_Reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: i_IF_ReqValid in 1, o_IF_ReqReady out 1, i_IF_Addr in 32  fetch read request (word-aligned).
REQ-005 SHALL have ports: i_D_ReqValid in 1, o_D_ReqReady out 1, i_D_Addr in 32, i_D_WData in 32, i_D_ByteEnable in 4, i_D_Write in 1  data request.
REQ-006 SHALL have ports: o_IF_RespValid out 1, o_D_RespValid out 1, o_RData out 32  response, shared read data.
REQ-007 SHALL have ports: o_Mem_Valid out 1, i_Mem_Ready in 1, o_Mem_Addr out 32, o_Mem_WData out 32, o_Mem_ByteEnable out 4, o_Mem_Write out 1  memory command.
REQ-008 SHALL have ports: i_Mem_RespValid in 1, i_Mem_RData in 32  memory response (returned for reads and writes).
REQ-009 SHALL have ports: o_Busy out 1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; one transaction outstanding at most.
REQ-011 In IDLE, SHALL pick one winner among valid requesters, assert only its ReqReady combinationally in that cycle, latch its addr/wdata/byte-enable/write and owner at the edge, go to ISSUE.
REQ-012 ReqReady SHALL be low in every non-IDLE state and in IDLE with no valid request.
REQ-013 Fetch transactions SHALL drive o_Mem_Write=0, o_Mem_ByteEnable=4'b1111, o_Mem_WData=0.
REQ-014 In ISSUE, SHALL hold o_Mem_Valid=1 with stable latched fields until i_Mem_Ready=1 at an edge, then go to WAIT; o_Mem_Valid=0 in all other states.
REQ-015 In WAIT, on i_Mem_RespValid=1 SHALL register i_Mem_RData into o_RData and go to DONE; i_Mem_RespValid outside WAIT is ignored.
REQ-016 In DONE, SHALL assert exactly the owner's RespValid for one cycle with o_RData stable, then go to IDLE.
REQ-017 Minimum latency: ReqReady cycle to RespValid = 3 cycles with i_Mem_Ready and i_Mem_RespValid asserted immediately.
REQ-018 Simultaneous requests: data SHALL win by default; requests arriving in DONE are first considered in the following IDLE cycle.
REQ-019 Back-to-back: a request held valid through DONE SHALL be granted in the next IDLE cycle (4-cycle throughput minimum).
REQ-020 o_RData SHALL retain its last value outside DONE.

Reset
REQ-021 Asserting i_Reset_n=0 at any time, including mid-transaction, SHALL immediately force IDLE, abandon the in-flight transaction without a response, and clear the starvation counter.
REQ-022 Reset values: all Ready/RespValid/o_Mem_Valid/o_Mem_Write/o_Busy = 0; o_RData, o_Mem_Addr, o_Mem_WData = 0; o_Mem_ByteEnable = 0.

Configuration
REQ-023 Macro ARB_STARVATION_GUARD_EN SHALL control the fetch starvation guard.
REQ-024 Defined: 4-bit counter increments on each data grant while i_IF_ReqValid=1, saturating at STARVE_LIMIT; on a fetch grant it clears; when counter==STARVE_LIMIT and both request, fetch SHALL win.
REQ-025 Undefined: strict data priority; counter and STARVE_LIMIT logic absent; parameter retained but unused.

Verification
REQ-026 Fetch only, addr 0x0000_0100, memory ready/resp immediate, RData 0x0000_0013 -> o_IF_RespValid pulse 3 cycles after grant, o_RData=0x13.
REQ-027 Both valid same cycle, fetch 0x0, data write 0x2000 WData 0xDEADBEEF BE 4'b0011 -> data granted first, o_Mem_Write=1, BE=0011, then fetch granted in following IDLE.
REQ-028 i_Mem_Ready held low 5 cycles in ISSUE -> o_Mem_Valid and fields stable all 5 cycles, no ReqReady asserted.
REQ-029 With ARB_STARVATION_GUARD_EN, STARVE_LIMIT=4, both held valid continuously -> grant order D,D,D,D,IF,D,D,D,D,IF; without macro -> data only.
REQ-030 i_Reset_n pulsed low during WAIT -> o_Busy=0 immediately, no RespValid, next request granted normally after release.
